sram_port_arbiter: RTL and testbench

- Single owner of the accelerator's RAM256 port. It replaces the separate SRAM drivers in the Wishbone slave and in the memory controller.
- Arbitrates three requesters: host (Wishbone slave side), matrix multiplication engine and matrix convolution engine. All three use the engine memory handshake: 2-bit op (01 read, 11 write, 00 none) and a one-cycle done pulse.
- Sequences each granted access through RAM256's one-cycle read latency. Returns read data on a shared bus.

---
 rtl/kicp_mem_pkg.sv | 27 ++
 rtl/rr_arb3.sv | 72 +++++++
 rtl/sram_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kicp_mem_pkg.sv
// Shared definitions for the engine memory handshake and the RAM256 port arbiter.
package kicp_mem_pkg;

    localparam int KICP_SRAM_AWIDTH = 8;

    localparam logic [1:0] MEM_OP_NONE    = 2'b00;
    localparam logic [1:0] MEM_OP_READ    = 2'b01;
    localparam logic [1:0] MEM_OP_ILLEGAL = 2'b10;
    localparam logic [1:0] MEM_OP_WRITE   = 2'b11;

    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_HOST  = 2'd1;
    localparam logic [1:0] GNT_MMUL  = 2'd2;
    localparam logic [1:0] GNT_MCONV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    function automatic logic op_is_valid(input logic [1:0] op);
        return (op != MEM_OP_NONE) && (op != MEM_OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-requester arbiter (bit 0 host, bit 1 mmul, bit 2 mconv) with optional host priority.
module rr_arb3
    import kicp_mem_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [2:0] req_i,
    input  logic       host_prio_i,
    input  logic       adv_i,
    output logic [2:0] gnt_o
);

    // ptr_q holds the grant id of the requester with highest round-robin priority.
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] rr_req_s;

    function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
        logic [2:0] g;
        g = 3'b000;
        if (req[a]) begin
            g[a] = 1'b1;
        end else if (req[b]) begin
            g[b] = 1'b1;
        end else if (req[c]) begin
            g[c] = 1'b1;
        end else begin
            g = 3'b000;
        end
        return g;
    endfunction

    // Winner selection: host override first, then rotation starting at the pointer.
    always_comb begin
        rr_req_s = host_prio_i ? {req_i[2:1], 1'b0} : req_i;
        gnt_o    = 3'b000;
        if (host_prio_i && req_i[0]) begin
            gnt_o = 3'b001;
        end else begin
            case (ptr_q)
                GNT_MMUL:  gnt_o = pick(rr_req_s, 2'd1, 2'd2, 2'd0);
                GNT_MCONV: gnt_o = pick(rr_req_s, 2'd2, 2'd0, 2'd1);
                default:   gnt_o = pick(rr_req_s, 2'd0, 2'd1, 2'd2);
            endcase
        end
    end

    // Pointer moves past the winner; a priority host grant leaves the engine rotation alone.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            case (gnt_o)
                3'b001:  ptr_d = host_prio_i ? ptr_q : GNT_MMUL;
                3'b010:  ptr_d = GNT_MCONV;
                3'b100:  ptr_d = host_prio_i ? GNT_MMUL : GNT_HOST;
                default: ptr_d = ptr_q;
            endcase
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ptr_q <= GNT_MMUL;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Sole owner of the RAM256 port: arbitrates host, mmul and mconv and sequences the
// one-cycle read latency as IDLE -> ISSUE -> CAPTURE -> DONE.
module sram_port_arbiter
    import kicp_mem_pkg::*;
#(
    parameter int AWIDTH    = KICP_SRAM_AWIDTH,
    parameter int DWIDTH    = 32,
    parameter int HOST_PRIO = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [1:0]        host_op,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic              host_done,
    input  logic [1:0]        mmul_op,
    input  logic [AWIDTH-1:0] mmul_addr,
    input  logic [DWIDTH-1:0] mmul_wdata,
    output logic              mmul_done,
    input  logic [1:0]        mconv_op,
    input  logic [AWIDTH-1:0] mconv_addr,
    input  logic [DWIDTH-1:0] mconv_wdata,
    output logic              mconv_done,
    output logic [DWIDTH-1:0] rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_di,
    input  logic [DWIDTH-1:0] sram_do,
    output logic              busy,
    output logic [1:0]        grant,
    output logic              err
);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              wr_q, wr_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              en_q, en_d;
    logic [3:0]        we_q, we_d;
    logic [2:0]        done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [2:0]        req_s, gnt_s;
    logic              illegal_s, adv_s;

    assign req_s = {op_is_valid(mconv_op), op_is_valid(mmul_op), op_is_valid(host_op)};
    assign illegal_s = (host_op == MEM_OP_ILLEGAL) || (mmul_op == MEM_OP_ILLEGAL) ||
                       (mconv_op == MEM_OP_ILLEGAL);
    assign adv_s = (state_q == ST_IDLE);

    rr_arb3 u_arb (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .req_i       (req_s),
        .host_prio_i (HOST_PRIO != 0),
        .adv_i       (adv_s),
        .gnt_o       (gnt_s)
    );

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        en_d    = 1'b0;
        we_d    = 4'b0000;
        done_d  = 3'b000;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (illegal_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                case (gnt_s)
                    3'b001: begin
                        grant_d = GNT_HOST;
                        wr_d    = (host_op == MEM_OP_WRITE);
                        addr_d  = host_addr;
                        wdata_d = host_wdata;
                    end
                    3'b010: begin
                        grant_d = GNT_MMUL;
                        wr_d    = (mmul_op == MEM_OP_WRITE);
                        addr_d  = mmul_addr;
                        wdata_d = mmul_wdata;
                    end
                    3'b100: begin
                        grant_d = GNT_MCONV;
                        wr_d    = (mconv_op == MEM_OP_WRITE);
                        addr_d  = mconv_addr;
                        wdata_d = mconv_wdata;
                    end
                    default: grant_d = GNT_NONE;
                endcase
                if (gnt_s != 3'b000) begin
                    state_d = ST_ISSUE;
                    en_d    = 1'b1;
                    we_d    = wr_d ? 4'b1111 : 4'b0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                // RAM256 output for the read issued last cycle is valid now.
                if (!wr_q) begin
                    rdata_d = sram_do;
                end else begin
                    rdata_d = rdata_q;
                end
                case (grant_q)
                    GNT_HOST:  done_d = 3'b001;
                    GNT_MMUL:  done_d = 3'b010;
                    GNT_MCONV: done_d = 3'b100;
                    default:   done_d = 3'b000;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 4'b0000;
            done_q  <= 3'b000;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign host_done  = done_q[0];
    assign mmul_done  = done_q[1];
    assign mconv_done = done_q[2];
    assign rdata      = rdata_q;
    assign sram_en    = en_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_di    = wdata_q;
    assign busy       = busy_q;
    assign grant      = grant_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed vectors, contention sequences and
// a randomized run against a transaction-level reference model.
module tb_sram_port_arbiter;
    import kicp_mem_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [1:0]  host_op, mmul_op, mconv_op;
    logic [7:0]  host_addr, mmul_addr, mconv_addr;
    logic [31:0] host_wdata, mmul_wdata, mconv_wdata;
    logic        host_done, mmul_done, mconv_done;
    logic [31:0] rdata, sram_di, sram_do;
    logic        sram_en, busy, err;
    logic [3:0]  sram_we;
    logic [7:0]  sram_addr;
    logic [1:0]  grant;

    logic [1:0]  b_host_op, b_mmul_op, b_mconv_op;
    logic        b_host_done, b_mmul_done, b_mconv_done;
    logic [31:0] b_rdata, b_sram_di, b_sram_do;
    logic        b_sram_en, b_busy, b_err;
    logic [3:0]  b_sram_we;
    logic [7:0]  b_sram_addr;
    logic [1:0]  b_grant;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    int checks = 0;
    int failures = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    sram_port_arbiter #(.HOST_PRIO(1)) u_dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .host_op(host_op), .host_addr(host_addr), .host_wdata(host_wdata), .host_done(host_done),
        .mmul_op(mmul_op), .mmul_addr(mmul_addr), .mmul_wdata(mmul_wdata), .mmul_done(mmul_done),
        .mconv_op(mconv_op), .mconv_addr(mconv_addr), .mconv_wdata(mconv_wdata),
        .mconv_done(mconv_done), .rdata(rdata), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_di(sram_di), .sram_do(sram_do), .busy(busy),
        .grant(grant), .err(err)
    );

    sram_port_arbiter #(.HOST_PRIO(0)) u_dut_rr (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .host_op(b_host_op), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_done(b_host_done),
        .mmul_op(b_mmul_op), .mmul_addr(mmul_addr), .mmul_wdata(mmul_wdata),
        .mmul_done(b_mmul_done),
        .mconv_op(b_mconv_op), .mconv_addr(mconv_addr), .mconv_wdata(mconv_wdata),
        .mconv_done(b_mconv_done), .rdata(b_rdata), .sram_en(b_sram_en), .sram_we(b_sram_we),
        .sram_addr(b_sram_addr), .sram_di(b_sram_di), .sram_do(b_sram_do), .busy(b_busy),
        .grant(b_grant), .err(b_err)
    );

    // RAM256 models: one-cycle read latency, byte write enables, bench preload port on mem_a.
    always @(posedge wb_clk_i) begin
        if (pl_en) mem_a[pl_addr] <= pl_data;
        if (sram_en) begin
            for (int i = 0; i < 4; i++)
                if (sram_we[i]) mem_a[sram_addr][8*i +: 8] <= sram_di[8*i +: 8];
            sram_do <= mem_a[sram_addr];
        end
    end

    always @(posedge wb_clk_i) begin
        if (b_sram_en) begin
            for (int i = 0; i < 4; i++)
                if (b_sram_we[i]) mem_b[b_sram_addr][8*i +: 8] <= b_sram_di[8*i +: 8];
            b_sram_do <= mem_b[b_sram_addr];
        end
    end

    typedef struct {
        int          r;        // requester index: 0 host, 1 mmul, 2 mconv
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [2:0] oh(input int r);
        logic [2:0] one;
        one = 3'b001;
        return one << r;
    endfunction

    task automatic drive(input int r, input logic [1:0] op, input logic [7:0] a,
                         input logic [31:0] d);
        case (r)
            0: begin host_op = op;  host_addr = a;  host_wdata = d;  end
            1: begin mmul_op = op;  mmul_addr = a;  mmul_wdata = d;  end
            2: begin mconv_op = op; mconv_addr = a; mconv_wdata = d; end
            default: ;
        endcase
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    // One isolated transaction on u_dut, checked cycle by cycle from request (t) to t+4.
    task automatic do_single(input vec_t v);
        logic [3:0] exp_we;
        exp_we = (v.op == MEM_OP_WRITE) ? 4'b1111 : 4'b0000;
        drive(v.r, v.op, v.addr, v.wdata);
        tick();
        chk("issue_en", {31'd0, sram_en}, 32'd1);
        chk("issue_addr", {24'd0, sram_addr}, {24'd0, v.addr});
        chk("issue_we", {28'd0, sram_we}, {28'd0, exp_we});
        chk("issue_grant", {30'd0, grant}, v.r + 1);
        chk("issue_busy", {31'd0, busy}, 32'd1);
        if (v.op == MEM_OP_WRITE) chk("issue_di", sram_di, v.wdata);
        tick();
        chk("capture_en", {31'd0, sram_en}, 32'd0);
        chk("capture_we", {28'd0, sram_we}, 32'd0);
        chk("capture_done", {29'd0, mconv_done, mmul_done, host_done}, 32'd0);
        tick();
        chk("done_pulse", {29'd0, mconv_done, mmul_done, host_done}, {29'd0, oh(v.r)});
        chk("done_rdata", rdata, v.exp_rdata);
        drive(v.r, MEM_OP_NONE, v.addr, v.wdata);
        tick();
        chk("idle_done", {29'd0, mconv_done, mmul_done, host_done}, 32'd0);
        chk("idle_grant", {30'd0, grant}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_en"}, {31'd0, sram_en}, 32'd0);
        chk({nm, "_we"}, {28'd0, sram_we}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_grant"}, {30'd0, grant}, 32'd0);
        chk({nm, "_done"}, {29'd0, mconv_done, mmul_done, host_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          exp_seq [6];
        logic [31:0] exp_rd  [3];
        int          dcount;
        logic [1:0]  m_op   [3];
        logic [7:0]  m_addr [3];
        logic [31:0] m_wd   [3];
        bit          pend   [3];
        logic [31:0] shadow [16];
        logic [31:0] m_rdata;
        int          eng_ptr, w;

        host_op = 2'b00; mmul_op = 2'b00; mconv_op = 2'b00;
        b_host_op = 2'b00; b_mmul_op = 2'b00; b_mconv_op = 2'b00;
        host_addr = 8'd0; mmul_addr = 8'd0; mconv_addr = 8'd0;
        host_wdata = 32'd0; mmul_wdata = 32'd0; mconv_wdata = 32'd0;
        pl_en = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
        wb_rst_i = 1'b1;
        tick(); tick();
        chk_quiet("rst");
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", {24'd0, sram_addr}, 32'd0);
        wb_rst_i = 1'b0;
        tick();
        chk_quiet("post_rst");

        // Host read of preloaded word.
        preload(8'h05, 32'hDEADBEEF);
        do_single('{0, MEM_OP_READ, 8'h05, 32'd0, 32'hDEADBEEF});

        // Reset asserted while a read is in CAPTURE.
        drive(0, MEM_OP_READ, 8'h05, 32'd0);
        tick(); tick();
        #2 wb_rst_i = 1'b1;
        #1;
        chk_quiet("midrst");
        chk("midrst_rdata", rdata, 32'd0);
        drive(0, MEM_OP_NONE, 8'h05, 32'd0);
        tick();
        chk_quiet("midrst_t3");
        wb_rst_i = 1'b0;
        tick();
        chk_quiet("midrst_rel");

        vecs[0] = '{1, MEM_OP_WRITE, 8'h10, 32'h12345678, 32'h00000000};
        vecs[1] = '{2, MEM_OP_READ,  8'h10, 32'h0,        32'h12345678};
        vecs[2] = '{0, MEM_OP_WRITE, 8'hFF, 32'hA5A50F0F, 32'h12345678};
        vecs[3] = '{1, MEM_OP_READ,  8'hFF, 32'h0,        32'hA5A50F0F};
        vecs[4] = '{0, MEM_OP_WRITE, 8'h00, 32'hCAFEF00D, 32'hA5A50F0F};
        vecs[5] = '{2, MEM_OP_READ,  8'h00, 32'h0,        32'hCAFEF00D};
        for (int i = 0; i < 6; i++) do_single(vecs[i]);

        // Illegal op on mconv alongside a host read.
        chk("err_before", {31'd0, err}, 32'd0);
        mconv_op = MEM_OP_ILLEGAL;
        do_single('{0, MEM_OP_READ, 8'h10, 32'd0, 32'h12345678});
        chk("err_set", {31'd0, err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("illegal_idle");
            chk("err_sticky", {31'd0, err}, 32'd1);
        end
        mconv_op = MEM_OP_NONE;
        tick();
        chk("err_hold", {31'd0, err}, 32'd1);

        // Three-way contention with host priority; host drops after its second grant.
        exp_seq = '{0, 0, 1, 2, 1, 2};
        exp_rd  = '{32'h12345678, 32'hA5A50F0F, 32'hCAFEF00D};
        drive(0, MEM_OP_READ, 8'h10, 32'd0);
        drive(1, MEM_OP_READ, 8'hFF, 32'd0);
        drive(2, MEM_OP_READ, 8'h00, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("prio_grant", {30'd0, grant}, exp_seq[k] + 1);
            tick(); tick();
            chk("prio_done", {29'd0, mconv_done, mmul_done, host_done}, {29'd0, oh(exp_seq[k])});
            chk("prio_rdata", rdata, exp_rd[exp_seq[k]]);
            if (k == 1) host_op = MEM_OP_NONE;
            if (k == 5) begin mmul_op = MEM_OP_NONE; mconv_op = MEM_OP_NONE; end
            tick();
        end
        chk_quiet("prio_end");

        // Round-robin instance: lone mconv access first, then six contended accesses.
        b_mconv_op = MEM_OP_READ;
        tick();
        chk("rr_lone_grant", {30'd0, b_grant}, 32'd3);
        tick(); tick();
        chk("rr_lone_done", {31'd0, b_mconv_done}, 32'd1);
        b_mconv_op = MEM_OP_NONE;
        tick();
        exp_seq = '{0, 1, 2, 0, 1, 2};
        dcount = 0;
        b_host_op = MEM_OP_READ; b_mmul_op = MEM_OP_READ; b_mconv_op = MEM_OP_READ;
        for (int k = 0; k < 6; k++) begin
            tick();
            dcount += b_host_done + b_mmul_done + b_mconv_done;
            chk("rr_grant", {30'd0, b_grant}, exp_seq[k] + 1);
            tick();
            dcount += b_host_done + b_mmul_done + b_mconv_done;
            tick();
            dcount += b_host_done + b_mmul_done + b_mconv_done;
            chk("rr_done", {29'd0, b_mconv_done, b_mmul_done, b_host_done},
                {29'd0, oh(exp_seq[k])});
            if (k == 5) begin
                b_host_op = MEM_OP_NONE; b_mmul_op = MEM_OP_NONE; b_mconv_op = MEM_OP_NONE;
            end
            tick();
            dcount += b_host_done + b_mmul_done + b_mconv_done;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            dcount += b_host_done + b_mmul_done + b_mconv_done;
        end
        chk("rr_done_count", dcount, 32'd6);

        // Randomized traffic on the host-priority instance against a transaction model.
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        tick();
        chk("rand_err_clear", {31'd0, err}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            shadow[a] = $urandom;
            preload(a[7:0], shadow[a]);
        end
        for (int r = 0; r < 3; r++) pend[r] = 1'b0;
        eng_ptr = 1;
        m_rdata = 32'd0;
        for (int n = 0; n < 150; n++) begin
            for (int r = 0; r < 3; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r]   = 1'b1;
                    m_op[r]   = ($urandom_range(0, 1) == 1) ? MEM_OP_WRITE : MEM_OP_READ;
                    m_addr[r] = 8'($urandom_range(0, 15));
                    m_wd[r]   = $urandom;
                    drive(r, m_op[r], m_addr[r], m_wd[r]);
                end
            end
            if (!pend[0] && !pend[1] && !pend[2]) begin
                tick();
                chk_quiet("rand_idle");
                continue;
            end
            if (pend[0]) w = 0;
            else if (pend[eng_ptr]) w = eng_ptr;
            else w = 3 - eng_ptr;
            if (w != 0) eng_ptr = 3 - w;
            tick();
            chk("rand_grant", {30'd0, grant}, w + 1);
            chk("rand_en", {31'd0, sram_en}, 32'd1);
            chk("rand_addr", {24'd0, sram_addr}, {24'd0, m_addr[w]});
            chk("rand_we", {28'd0, sram_we}, (m_op[w] == MEM_OP_WRITE) ? 32'd15 : 32'd0);
            tick(); tick();
            if (m_op[w] == MEM_OP_READ) m_rdata = shadow[m_addr[w][3:0]];
            else shadow[m_addr[w][3:0]] = m_wd[w];
            chk("rand_done", {29'd0, mconv_done, mmul_done, host_done}, {29'd0, oh(w)});
            chk("rand_rdata", rdata, m_rdata);
            pend[w] = 1'b0;
            drive(w, MEM_OP_NONE, m_addr[w], m_wd[w]);
            tick();
            chk("rand_busy", {31'd0, busy}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
